// File: rtl/traffic_queue_sensor.sv
// traffic_queue_sensor: per-street loop-detector debounce and waiting-car
// queue that produces the TA/TB traffic-present inputs of the light controller.
// Cars retire while the street's own light (LA/LB feedback) is GREEN.
// Optional build macro LIGHT_CONFLICT_CHECK_EN: adds sticky conflict_err and
// suppresses departures on both streets while neither light is RED.
module traffic_queue_sensor #(
   parameter int unsigned DEBOUNCE_CYCLES = 3,
   parameter int unsigned DEPART_CYCLES   = 4,
   parameter int unsigned QUEUE_W         = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               car_a_raw,
   input  logic               car_b_raw,
   input  logic [1:0]         LA,
   input  logic [1:0]         LB,
   output logic               TA,
   output logic               TB,
   output logic [QUEUE_W-1:0] count_a,
   output logic [QUEUE_W-1:0] count_b,
   output logic               overflow_a,
   output logic               overflow_b
`ifdef LIGHT_CONFLICT_CHECK_EN
   ,
   output logic               conflict_err
`endif
);

   localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned TMR_W = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
   localparam logic [DEB_W-1:0]   DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(DEPART_CYCLES - 1);
   localparam logic [QUEUE_W-1:0] CNT_MAX  = '1;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_TIMING = 1'b1
   } dep_state_t;

   // index 0 = street A, index 1 = street B
   logic [1:0]         w_raw;
   logic [1:0]         w_green;
   logic               w_conflict;

   logic [1:0]         r_deb;
   logic [DEB_W-1:0]   r_deb_cnt [2];
   dep_state_t         r_state   [2];
   logic [TMR_W-1:0]   r_timer   [2];
   logic [QUEUE_W-1:0] r_count   [2];
   logic [1:0]         r_ovf;

   logic [1:0]         w_deb_nxt;
   logic [DEB_W-1:0]   w_deb_cnt_nxt [2];
   logic [1:0]         w_arrival;
   logic [1:0]         w_run;
   logic [1:0]         w_depart;
   logic [TMR_W-1:0]   w_timer_cur   [2];
   dep_state_t         w_state_nxt   [2];
   logic [TMR_W-1:0]   w_timer_nxt   [2];
   logic [QUEUE_W-1:0] w_count_nxt   [2];
   logic [1:0]         w_ovf_nxt;

   assign w_raw   = {car_b_raw, car_a_raw};
   assign w_green = {LB == 2'b00, LA == 2'b00};

`ifdef LIGHT_CONFLICT_CHECK_EN
   logic r_conflict;

   // both streets non-RED (encoding 1x is RED)
   assign w_conflict = ~LA[1] & ~LB[1];

   // sticky conflict flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (!reset) r_conflict <= 1'b0;
      else        r_conflict <= r_conflict | w_conflict;
   end

   assign conflict_err = r_conflict;
`else
   assign w_conflict = 1'b0;
`endif

   // next-state: debounce, departure FSM/timer and queue count per street
   always_comb begin
      w_deb_nxt = r_deb;
      w_arrival = '0;
      w_run     = '0;
      w_depart  = '0;
      w_ovf_nxt = r_ovf;
      for (int i = 0; i < 2; i++) begin
         w_deb_cnt_nxt[i] = '0;
         w_timer_cur[i]   = '0;
         w_state_nxt[i]   = S_IDLE;
         w_timer_nxt[i]   = '0;
         w_count_nxt[i]   = r_count[i];

         if (w_raw[i] != r_deb[i]) begin
            if (r_deb_cnt[i] == DEB_LAST) begin
               w_deb_nxt[i] = ~r_deb[i];
               w_arrival[i] = ~r_deb[i];
            end else begin
               w_deb_cnt_nxt[i] = r_deb_cnt[i] + DEB_W'(1);
            end
         end

         w_run[i]       = w_green[i] && (r_count[i] != '0);
         w_timer_cur[i] = (r_state[i] == S_TIMING) ? r_timer[i] : '0;
         w_depart[i]    = w_run[i] && !w_conflict && (w_timer_cur[i] == TMR_LAST);

         if (w_run[i]) begin
            w_state_nxt[i] = S_TIMING;
            if (w_conflict)                     w_timer_nxt[i] = w_timer_cur[i];
            else if (w_timer_cur[i] != TMR_LAST) w_timer_nxt[i] = w_timer_cur[i] + TMR_W'(1);
         end

         if (w_arrival[i] && !w_depart[i]) begin
            if (r_count[i] == CNT_MAX) w_ovf_nxt[i]   = 1'b1;
            else                       w_count_nxt[i] = r_count[i] + QUEUE_W'(1);
         end else if (w_depart[i] && !w_arrival[i]) begin
            w_count_nxt[i] = r_count[i] - QUEUE_W'(1);
         end
      end
   end

   // state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_deb <= '0;
         r_ovf <= '0;
         for (int i = 0; i < 2; i++) begin
            r_deb_cnt[i] <= '0;
            r_state[i]   <= S_IDLE;
            r_timer[i]   <= '0;
            r_count[i]   <= '0;
         end
      end else begin
         r_deb <= w_deb_nxt;
         r_ovf <= w_ovf_nxt;
         for (int i = 0; i < 2; i++) begin
            r_deb_cnt[i] <= w_deb_cnt_nxt[i];
            r_state[i]   <= w_state_nxt[i];
            r_timer[i]   <= w_timer_nxt[i];
            r_count[i]   <= w_count_nxt[i];
         end
      end
   end

   assign count_a    = r_count[0];
   assign count_b    = r_count[1];
   assign TA         = (r_count[0] != '0);
   assign TB         = (r_count[1] != '0);
   assign overflow_a = r_ovf[0];
   assign overflow_b = r_ovf[1];

endmodule

// File: tb/tb_traffic_queue_sensor.sv
// Bench for traffic_queue_sensor: directed scenarios plus randomized traffic
// checked against a queue/streak reference model.
module tb_traffic_queue_sensor;

   localparam int DEB  = 3;
   localparam int DEP  = 4;
   localparam int MAXQ = 15;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       car_a_raw = 1'b0;
   logic       car_b_raw = 1'b0;
   logic [1:0] LA = 2'b10;
   logic [1:0] LB = 2'b10;
   logic       TA, TB, overflow_a, overflow_b;
   logic [3:0] count_a, count_b;
`ifdef LIGHT_CONFLICT_CHECK_EN
   logic       conflict_err;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   bit m_deb    [2];
   int m_run    [2];
   int m_cnt    [2];
   int m_streak [2];
   bit m_ovf    [2];
   bit m_conf;

   logic [11:0] dut_vec;
   assign dut_vec = {TA, TB, count_a, count_b, overflow_a, overflow_b};

   traffic_queue_sensor dut (
      .clk(clk), .reset(reset), .car_a_raw(car_a_raw), .car_b_raw(car_b_raw),
      .LA(LA), .LB(LB), .TA(TA), .TB(TB), .count_a(count_a), .count_b(count_b),
      .overflow_a(overflow_a), .overflow_b(overflow_b)
`ifdef LIGHT_CONFLICT_CHECK_EN
      , .conflict_err(conflict_err)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] exp_vec();
      return {1'(m_cnt[0] != 0), 1'(m_cnt[1] != 0), 4'(m_cnt[0]), 4'(m_cnt[1]),
              1'(m_ovf[0]), 1'(m_ovf[1])};
   endfunction

   // model: one rising edge with the currently applied inputs
   task automatic model_edge();
      bit raw [2];
      bit grn [2];
      bit arr, dep, conf;
      raw[0] = car_a_raw; raw[1] = car_b_raw;
      grn[0] = (LA == 2'b00); grn[1] = (LB == 2'b00);
      conf = 1'b0;
`ifdef LIGHT_CONFLICT_CHECK_EN
      conf = (LA inside {2'b00, 2'b01}) && (LB inside {2'b00, 2'b01});
`endif
      if (!reset) begin
         for (int c = 0; c < 2; c++) begin
            m_deb[c] = 0; m_run[c] = 0; m_cnt[c] = 0; m_streak[c] = 0; m_ovf[c] = 0;
         end
         m_conf = 0;
         return;
      end
      for (int c = 0; c < 2; c++) begin
         arr = 0; dep = 0;
         if (raw[c] != m_deb[c]) begin
            m_run[c]++;
            if (m_run[c] == DEB) begin
               m_deb[c] = !m_deb[c];
               m_run[c] = 0;
               arr = m_deb[c];
            end
         end else begin
            m_run[c] = 0;
         end
         if (grn[c] && m_cnt[c] > 0) begin
            if (!conf) begin
               m_streak[c]++;
               if (m_streak[c] == DEP) begin
                  dep = 1;
                  m_streak[c] = 0;
               end
            end
         end else begin
            m_streak[c] = 0;
         end
         if (arr && !dep) begin
            if (m_cnt[c] == MAXQ) m_ovf[c] = 1;
            else                  m_cnt[c]++;
         end else if (dep && !arr) begin
            m_cnt[c]--;
         end
      end
      m_conf = m_conf | conf;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b0;
      repeat (n) step();
      reset = 1'b1;
   endtask

   task automatic pulse(input int ch);
      if (ch == 0) car_a_raw = 1'b1; else car_b_raw = 1'b1;
      repeat (DEB) step();
      if (ch == 0) car_a_raw = 1'b0; else car_b_raw = 1'b0;
      repeat (DEB) step();
   endtask

   task automatic test_reset();
      car_a_raw = 1'b1; LA = 2'b00; LB = 2'b10;
      do_reset(2);
      n_tests++;
      if (dut_vec !== 12'h000) begin
         n_fail++; $display("FAIL reset_state outputs=%h exp=%h", dut_vec, 12'h000);
      end
      LA = 2'b10;
      step(); step();
      n_tests++;
      if (count_a !== 4'd0) begin
         n_fail++; $display("FAIL reset_edge2 count_a=%0d exp=0", count_a);
      end
      step();
      n_tests++;
      if (count_a !== 4'd1 || TA !== 1'b1) begin
         n_fail++; $display("FAIL reset_latency count_a=%0d TA=%b exp=1/1", count_a, TA);
      end
      car_a_raw = 1'b0;
   endtask

   task automatic test_debounce();
      LA = 2'b10; LB = 2'b10; car_a_raw = 1'b0;
      do_reset(1);
      car_b_raw = 1'b1; step(); step();
      car_b_raw = 1'b0; step(); step(); step();
      n_tests++;
      if (count_b !== 4'd0 || TB !== 1'b0) begin
         n_fail++; $display("FAIL debounce_short count_b=%0d TB=%b exp=0/0", count_b, TB);
      end
      car_b_raw = 1'b1; repeat (3) step();
      n_tests++;
      if (count_b !== 4'd1 || TB !== 1'b1) begin
         n_fail++; $display("FAIL debounce_valid count_b=%0d TB=%b exp=1/1", count_b, TB);
      end
      repeat (20) step();
      n_tests++;
      if (count_b !== 4'd1) begin
         n_fail++; $display("FAIL debounce_hold count_b=%0d exp=1", count_b);
      end
      car_b_raw = 1'b0; repeat (3) step();
      n_tests++;
      if (dut_vec !== exp_vec()) begin
         n_fail++; $display("FAIL debounce_model outputs=%h exp=%h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_departure();
      LA = 2'b10; LB = 2'b10;
      do_reset(1);
      pulse(0); pulse(0);
      n_tests++;
      if (count_a !== 4'd2) begin
         n_fail++; $display("FAIL depart_setup count_a=%0d exp=2", count_a);
      end
      LA = 2'b00;
      repeat (3) step();
      n_tests++;
      if (count_a !== 4'd2) begin
         n_fail++; $display("FAIL depart_edge3 count_a=%0d exp=2", count_a);
      end
      step();
      n_tests++;
      if (count_a !== 4'd1 || TA !== 1'b1) begin
         n_fail++; $display("FAIL depart_edge4 count_a=%0d TA=%b exp=1/1", count_a, TA);
      end
      repeat (3) step();
      n_tests++;
      if (count_a !== 4'd1) begin
         n_fail++; $display("FAIL depart_edge7 count_a=%0d exp=1", count_a);
      end
      step();
      n_tests++;
      if (count_a !== 4'd0 || TA !== 1'b0) begin
         n_fail++; $display("FAIL depart_edge8 count_a=%0d TA=%b exp=0/0", count_a, TA);
      end
      // yellow interruption discards partial progress
      LA = 2'b10;
      do_reset(1);
      pulse(0); pulse(0);
      LA = 2'b00; step(); step();
      LA = 2'b01; step();
      LA = 2'b00; repeat (3) step();
      n_tests++;
      if (count_a !== 4'd2) begin
         n_fail++; $display("FAIL depart_yellow_hold count_a=%0d exp=2", count_a);
      end
      step();
      n_tests++;
      if (count_a !== 4'd1) begin
         n_fail++; $display("FAIL depart_yellow_fire count_a=%0d exp=1", count_a);
      end
      LA = 2'b10;
   endtask

   task automatic test_saturation();
      LA = 2'b10; LB = 2'b10;
      do_reset(1);
      repeat (15) pulse(0);
      n_tests++;
      if (count_a !== 4'd15 || overflow_a !== 1'b0) begin
         n_fail++; $display("FAIL sat_15 count_a=%0d ovf=%b exp=15/0", count_a, overflow_a);
      end
      pulse(0);
      n_tests++;
      if (count_a !== 4'd15 || overflow_a !== 1'b1) begin
         n_fail++; $display("FAIL sat_16 count_a=%0d ovf=%b exp=15/1", count_a, overflow_a);
      end
      do_reset(1);
      n_tests++;
      if (overflow_a !== 1'b0 || count_a !== 4'd0) begin
         n_fail++; $display("FAIL sat_reset ovf=%b count_a=%0d exp=0/0", overflow_a, count_a);
      end
   endtask

   task automatic test_simultaneous();
      LA = 2'b10; LB = 2'b10;
      do_reset(1);
      repeat (15) pulse(0);
      LA = 2'b00; step();
      car_a_raw = 1'b1; step(); step();
      n_tests++;
      if (count_a !== 4'd15) begin
         n_fail++; $display("FAIL simul_pre count_a=%0d exp=15", count_a);
      end
      step();
      n_tests++;
      if (count_a !== 4'd15 || overflow_a !== 1'b0) begin
         n_fail++; $display("FAIL simul_both count_a=%0d ovf=%b exp=15/0", count_a, overflow_a);
      end
      LA = 2'b10; car_a_raw = 1'b0; repeat (3) step();
      n_tests++;
      if (dut_vec !== exp_vec()) begin
         n_fail++; $display("FAIL simul_model outputs=%h exp=%h", dut_vec, exp_vec());
      end
   endtask

`ifdef LIGHT_CONFLICT_CHECK_EN
   task automatic test_conflict();
      LA = 2'b10; LB = 2'b10;
      do_reset(1);
      repeat (3) pulse(0);
      LA = 2'b00; LB = 2'b01; step();
      n_tests++;
      if (conflict_err !== 1'b1 || count_a !== 4'd3) begin
         n_fail++; $display("FAIL conflict_set err=%b count_a=%0d exp=1/3", conflict_err, count_a);
      end
      LB = 2'b10; repeat (5) step();
      n_tests++;
      if (conflict_err !== 1'b1) begin
         n_fail++; $display("FAIL conflict_sticky err=%b exp=1", conflict_err);
      end
      LA = 2'b10;
   endtask
`endif

   task automatic test_random();
      logic [1:0] lights [4];
      lights[0] = 2'b00; lights[1] = 2'b01; lights[2] = 2'b10; lights[3] = 2'b11;
      LA = 2'b10; LB = 2'b10; car_a_raw = 1'b0; car_b_raw = 1'b0;
      do_reset(1);
      for (int k = 0; k < 1500; k++) begin
         reset = ($urandom_range(0, 199) != 0);
         if ($urandom_range(0, 3) == 0) car_a_raw = ~car_a_raw;
         if ($urandom_range(0, 3) == 0) car_b_raw = ~car_b_raw;
         if ($urandom_range(0, 15) == 0)
            LA = ($urandom_range(0, 1) != 0) ? 2'b00 : lights[$urandom_range(1, 3)];
         if ($urandom_range(0, 15) == 0)
            LB = ($urandom_range(0, 1) != 0) ? 2'b00 : lights[$urandom_range(1, 3)];
         step();
         n_tests++;
         if (dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL random cyc=%0d outputs=%h exp=%h", k, dut_vec, exp_vec());
         end
`ifdef LIGHT_CONFLICT_CHECK_EN
         n_tests++;
         if (conflict_err !== m_conf) begin
            n_fail++; $display("FAIL random_conflict cyc=%0d err=%b exp=%b", k, conflict_err, m_conf);
         end
`endif
      end
      reset = 1'b1;
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_departure();
      test_saturation();
      test_simultaneous();
`ifdef LIGHT_CONFLICT_CHECK_EN
      test_conflict();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
